// File: rtl/small_example_pkg.sv
// Shared types and the two inverse-stage functions of the 5-bit chain/scrambler decoder.
package small_example_pkg;

    localparam int unsigned WORD_W = 5;

    typedef logic [0:WORD_W-1] word_t;

    typedef enum logic {
        PRIME,
        RUN
    } dec_state_e;

    // Stage A: undo the output chain, recovering the encoder's scrambler state
    function automatic word_t chain_inv(input word_t w, input word_t p);
        word_t s;
        s[0] = ~(w[0] ^ p[4]);
        s[1] = ~(w[1] ^ p[0] ^ p[4]);
        s[2] = ~(w[2] ^ p[1]);
        s[3] = ~(w[3] ^ p[2]);
        s[4] = ~(w[4] ^ p[3]);
        return s;
    endfunction

    // Stage B: undo the scrambler, recovering the original data word
    function automatic word_t scr_inv(input word_t s, input word_t q);
        word_t d;
        d[0] = s[0] ^ q[4];
        d[1] = s[1] ^ q[0] ^ q[4];
        d[2] = s[2] ^ q[1];
        d[3] = s[3] ^ q[2];
        d[4] = s[4] ^ q[3];
        return d;
    endfunction

endpackage

// File: rtl/small_example_decoder.sv
// Channel-sink decoder: recovers data words from the encoder's output stream,
// with a priming FSM that checks the encoder's initial state and a one-deep
// output register under valid/ready flow control.
module small_example_decoder
    import small_example_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:4]       in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:4]       out_data,
    output logic             sync_err,
    output logic [CNT_W-1:0] word_cnt
);

    dec_state_e state_q, state_d;
    word_t      wprev, sprev;
    word_t      s_cur, d_cur;
    logic       accept;
    logic       load;
    logic       set_err;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign s_cur    = chain_inv(in_word, wprev);
    assign d_cur    = scr_inv(s_cur, sprev);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= PRIME;
        else        state_q <= state_d;
    end

    // Next state: first word after reset/resync primes history, later words emit data
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        set_err = 1'b0;
        if (sync_clr) begin
            state_d = PRIME;
        end else if (accept) begin
            case (state_q)
                PRIME: begin
                    state_d = RUN;
                    set_err = (s_cur != '0);
                end
                RUN: begin
                    load = 1'b1;
                end
                default: state_d = PRIME;
            endcase
        end
    end

    // Decoder history: previous received word and previous recovered scrambler state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wprev <= '0;
            sprev <= '0;
        end else if (sync_clr) begin
            wprev <= '0;
            sprev <= '0;
        end else if (accept) begin
            wprev <= in_word;
            sprev <= s_cur;
        end
    end

    // Output register; a load in the same cycle as a drain keeps out_valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (sync_clr) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= d_cur;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky sync error and saturating word counter survive resync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
            word_cnt <= '0;
        end else begin
            if (set_err) sync_err <= 1'b1;
            if (load && (word_cnt != '1)) word_cnt <= word_cnt + 1'b1;
        end
    end

endmodule

// File: doc/small_example_decoder.md
Name: small_example_decoder

Overview:
- Receiver-side inverse of the two-stage 5-bit scrambler/chain encoder.
- Takes the encoder's registered output word stream, one word per handshake.
- Stage A recovers the encoder's internal scrambler state; stage B recovers the original 5-bit data words.
- Sits at the channel sink with valid/ready flow control, a lock/priming FSM and a sync-check flag.

Parameters:
CNT_W, 16, width of the decoded-word counter (saturating)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
sync_clr  input  1  synchronous resync: returns history and FSM to reset state (encoder restarted)
in_valid  input  1  in_word valid
in_ready  output  1  decoder accepts in_word this cycle
in_word  input  [0:4]  encoded word (encoder output register value); bit 0 is leftmost literal bit
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts out_data
out_data  output  [0:4]  recovered data word
sync_err  output  1  sticky: first word after reset/resync did not decode to all-zero scrambler state
word_cnt  output  CNT_W  number of data words emitted, saturates at all-ones

Behaviour:
- Reset (rst_n low, async): wprev=00000, sprev=00000, FSM=PRIME, out_valid=0, out_data=00000, sync_err=0, word_cnt=0.
- Reset values match the encoder's reset state, so no seed exchange is needed.
- in_ready = !out_valid | out_ready (combinational, one-deep output register).
- Accept = in_valid & in_ready. Nothing changes on cycles without an accept, except output draining.
- Stage A, combinational, on accept (w = in_word, p = wprev):
  - s[0]=~(w[0]^p[4])
  - s[1]=~(w[1]^p[0]^p[4])
  - s[2]=~(w[2]^p[1])
  - s[3]=~(w[3]^p[2])
  - s[4]=~(w[4]^p[3])
- Stage B, combinational (q = sprev):
  - d[0]=s[0]^q[4]
  - d[1]=s[1]^q[0]^q[4]
  - d[2]=s[2]^q[1]
  - d[3]=s[3]^q[2]
  - d[4]=s[4]^q[3]
- On every accept: wprev<=in_word; sprev<=s.
- FSM PRIME, on accept:
  - s is the encoder's initial state; no output.
  - If s!=00000, set sync_err.
  - Go to RUN.
- FSM RUN, on accept: out_data<=d, out_valid<=1, word_cnt+=1 (saturating).
- Output drain: if out_valid & out_ready with no new load, out_valid<=0. Load and drain in the same cycle keeps out_valid=1 with the new data.
- Latency: the word for encoder input i appears on out_data the cycle after the (i+2)-th accepted word. There is one pipeline bubble at startup only.
- sync_clr has priority over accept in the same cycle; the word is dropped:
  - wprev, sprev, FSM and out_valid return to reset values.
  - sync_err and word_cnt are kept.
- sync_err clears only on rst_n.
- Async reset mid-stream discards the pending output word immediately.

Decomposition:
- Package small_example_pkg:
  - WORD_W=5
  - word_t ([0:4] logic)
  - dec_state_e {PRIME, RUN}
  - functions chain_inv(w,p) (stage A) and scr_inv(s,q) (stage B), reusable by the encoder model in benches.
- No sub-module; the two stages are package functions. The FSM and output register stay in this module.

Test Plan:
- Idle stream: after reset, feed 11111, 01000 with out_ready=1 -> first word produces no output, sync_err=0; second gives out_data=00000, out_valid=1, word_cnt=1.
- Single data bit: feed 11111, 11000 -> out_data=10000 one cycle after the second accept.
- Bad sync: first word after reset 00000 -> sync_err=1 sticky; decoding continues normally afterward.
- Backpressure: out_ready=0 while valid -> in_ready=0, out_data holds. Release with in_valid held -> load and drain occur in the same cycle with no word lost or duplicated.
- Golden loop: drive the encoder model from reset with in=00000..01001 on consecutive cycles, feed its outputs -> decoded stream is 00000..01000 in order. Encoder state reaches input_FF=11001, output_FF=01001 at cycle 10.
- Resync/reset: sync_clr asserted simultaneously with an accept -> word dropped, FSM=PRIME, word_cnt kept. rst_n pulsed with out_valid=1 -> out_valid=0 immediately.
